// File: rtl/layer_argmax_select_pkg.sv
// Shared types and helpers for layer_argmax_select and later comparator stages.
// Revision 1.0 - initial release.
`default_nettype none

package layer_argmax_select_pkg;

  typedef enum logic [0:0] {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  localparam int FRAME_CNT_W = 8;
  // Operand width of signed_gt; element widths up to this value are supported.
  localparam int CMP_W = 32;

  function automatic logic signed_gt(input logic signed [CMP_W-1:0] a,
                                     input logic signed [CMP_W-1:0] b);
    return a > b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/layer_argmax_select_if.sv
// Element stream and classification result interfaces of layer_argmax_select.
// Macro ARGMAX_VALUE_OUT_EN adds max_val to the result interface. Revision 1.0.
`default_nettype none

interface argmax_in_if #(
  parameter int T = 16
) ();
  logic                s_valid;
  logic                s_ready;
  logic signed [T-1:0] data_in;

  modport master (output s_valid, output data_in, input s_ready);
  modport slave  (input s_valid, input data_in, output s_ready);
endinterface

interface argmax_out_if #(
  parameter int T    = 16,
  parameter int LOGM = 3
) ();
  logic                                            m_valid;
  logic                                            m_ready;
  logic [LOGM-1:0]                                 class_idx;
  logic [layer_argmax_select_pkg::FRAME_CNT_W-1:0] frame_cnt;
`ifdef ARGMAX_VALUE_OUT_EN
  logic signed [T-1:0]                             max_val;

  modport master (output m_valid, output class_idx, output frame_cnt, output max_val, input m_ready);
  modport slave  (input m_valid, input class_idx, input frame_cnt, input max_val, output m_ready);
`else
  modport master (output m_valid, output class_idx, output frame_cnt, input m_ready);
  modport slave  (input m_valid, input class_idx, input frame_cnt, output m_ready);
`endif
endinterface

`default_nettype wire

// File: rtl/layer_argmax_select_cmp.sv
// argmax_cmp: combinational running-maximum update step (strict signed compare).
// Revision 1.0 - initial release.
`default_nettype none

module argmax_cmp
  import layer_argmax_select_pkg::*;
#(
  parameter int T    = 16,
  parameter int LOGM = 3
) (
  input  logic signed [T-1:0]  data_in,
  input  logic signed [T-1:0]  best_val,
  input  logic [LOGM-1:0]      best_idx,
  input  logic [LOGM-1:0]      elem_cnt,
  input  logic                 first,
  output logic signed [T-1:0]  next_val,
  output logic [LOGM-1:0]      next_idx
);

  logic take;

  // Strict greater-than keeps the earliest index on ties.
  always_comb begin
    take     = first || signed_gt(CMP_W'(data_in), CMP_W'(best_val));
    next_val = take ? data_in  : best_val;
    next_idx = take ? elem_cnt : best_idx;
  end

endmodule

`default_nettype wire

// File: rtl/layer_argmax_select.sv
// layer_argmax_select: argmax over each M-element frame, result on a valid/ready port.
// Macro ARGMAX_VALUE_OUT_EN exposes the winning value as max_val. Revision 1.0.
`default_nettype none

module layer_argmax_select
  import layer_argmax_select_pkg::*;
#(
  parameter int M    = 4,
  parameter int T    = 16,
  parameter int LOGM = $clog2(M + 1)
) (
  input  logic          clk,
  input  logic          reset,
  argmax_in_if.slave    up,
  argmax_out_if.master  dn
);

  localparam logic [LOGM-1:0] LAST = LOGM'(M - 1);

  state_t                 state;
  logic [LOGM-1:0]        elem_cnt;
  logic signed [T-1:0]    best_val;
  logic [LOGM-1:0]        best_idx;
  logic                   m_valid_q;
  logic [LOGM-1:0]        class_idx_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic signed [T-1:0]    next_val;
  logic [LOGM-1:0]        next_idx;
  logic                   in_fire;
  logic                   out_fire;

  // s_ready depends only on state; held low while reset is asserted.
  assign up.s_ready = reset && (state == ACC);
  assign in_fire    = up.s_valid && up.s_ready;
  assign out_fire   = m_valid_q && dn.m_ready;

  argmax_cmp #(
    .T    (T),
    .LOGM (LOGM)
  ) u_cmp (
    .data_in  (up.data_in),
    .best_val (best_val),
    .best_idx (best_idx),
    .elem_cnt (elem_cnt),
    .first    (elem_cnt == '0),
    .next_val (next_val),
    .next_idx (next_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ACC;
      elem_cnt    <= '0;
      best_val    <= '0;
      best_idx    <= '0;
      m_valid_q   <= 1'b0;
      class_idx_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      case (state)
        ACC: begin
          if (in_fire) begin
            best_val <= next_val;
            best_idx <= next_idx;
            if (elem_cnt == LAST) begin
              elem_cnt    <= '0;
              class_idx_q <= next_idx;
              m_valid_q   <= 1'b1;
              state       <= OUT;
            end else begin
              elem_cnt <= elem_cnt + LOGM'(1);
            end
          end
        end
        OUT: begin
          if (out_fire) begin
            m_valid_q   <= 1'b0;
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
            elem_cnt    <= '0;
            state       <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  assign dn.m_valid   = m_valid_q;
  assign dn.class_idx = class_idx_q;
  assign dn.frame_cnt = frame_cnt_q;

`ifdef ARGMAX_VALUE_OUT_EN
  logic signed [T-1:0] max_val_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_val_q <= '0;
    end else if (state == ACC && in_fire && elem_cnt == LAST) begin
      max_val_q <= next_val;
    end
  end

  assign dn.max_val = max_val_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_layer_argmax_select.sv
// Directed self-checking bench for layer_argmax_select (M=4, T=16).
// Revision 1.0 - initial release.
`default_nettype none

module tb_layer_argmax_select;

  localparam int M    = 4;
  localparam int T    = 16;
  localparam int LOGM = $clog2(M + 1);

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   hs_count;
  int   exp_frames;

  argmax_in_if  #(.T(T))               up ();
  argmax_out_if #(.T(T), .LOGM(LOGM))  dn ();

  layer_argmax_select #(
    .M (M),
    .T (T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .up    (up),
    .dn    (dn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result-handshake scoreboard.
  always @(posedge clk or negedge reset) begin
    if (!reset) hs_count <= 0;
    else if (dn.m_valid && dn.m_ready) hs_count <= hs_count + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_elem(input logic signed [T-1:0] v);
    int t;
    @(negedge clk);
    up.s_valid = 1'b1;
    up.data_in = v;
    t = 0;
    while (up.s_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      $display("FAIL send_timeout: s_ready=%b required 1", up.s_ready);
      n_fail++;
      n_checks++;
    end
    @(posedge clk);
  endtask

  task automatic gap(input int g);
    @(negedge clk);
    up.s_valid = 1'b0;
    up.data_in = 16'sh7fff;
    repeat (g - 1) @(negedge clk);
  endtask

  // Sends one frame; returns at the negedge after the last handshake.
  task automatic send_frame(input logic signed [T-1:0] a, input logic signed [T-1:0] b,
                            input logic signed [T-1:0] c, input logic signed [T-1:0] d,
                            input bit gaps);
    send_elem(a);
    if (gaps) gap(1);
    send_elem(b);
    if (gaps) gap(2);
    send_elem(c);
    if (gaps) gap(3);
    send_elem(d);
    @(negedge clk);
    up.s_valid = 1'b0;
    up.data_in = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    if (up.s_ready !== 1'b0) begin
      $display("FAIL reset_s_ready: got %b required 0", up.s_ready); n_fail++;
    end
    n_checks++;
    if (dn.m_valid !== 1'b0) begin
      $display("FAIL reset_m_valid: got %b required 0", dn.m_valid); n_fail++;
    end
    n_checks++;
    if (dn.class_idx !== '0) begin
      $display("FAIL reset_class_idx: got %0d required 0", dn.class_idx); n_fail++;
    end
    n_checks++;
    if (dn.frame_cnt !== 8'd0) begin
      $display("FAIL reset_frame_cnt: got %0d required 0", dn.frame_cnt); n_fail++;
    end
    n_checks++;
    reset = 1'b1;
    @(negedge clk);
    if (up.s_ready !== 1'b1) begin
      $display("FAIL post_reset_s_ready: got %b required 1", up.s_ready); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_basic();
    dn.m_ready = 1'b1;
    send_frame(16'sd5, 16'sd20, 16'sd7, 16'sd3, 1'b0);
    if (dn.m_valid !== 1'b1 || dn.class_idx !== 3'd1) begin
      $display("FAIL basic_result: m_valid=%b class_idx=%0d required 1/1", dn.m_valid, dn.class_idx);
      n_fail++;
    end
    n_checks++;
    if (up.s_ready !== 1'b0) begin
      $display("FAIL basic_s_ready_out: got %b required 0", up.s_ready); n_fail++;
    end
    n_checks++;
    @(negedge clk);
    exp_frames++;
    if (dn.m_valid !== 1'b0 || up.s_ready !== 1'b1) begin
      $display("FAIL basic_one_cycle: m_valid=%b s_ready=%b required 0/1", dn.m_valid, up.s_ready);
      n_fail++;
    end
    n_checks++;
    if (dn.frame_cnt !== 8'd1) begin
      $display("FAIL basic_frame_cnt: got %0d required 1", dn.frame_cnt); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_tie();
    send_frame(16'sd0, 16'sd9, 16'sd9, 16'sd0, 1'b0);
    if (dn.class_idx !== 3'd1) begin
      $display("FAIL tie_9: got %0d required 1", dn.class_idx); n_fail++;
    end
    n_checks++;
    exp_frames++;
    send_frame(16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
    if (dn.class_idx !== 3'd0) begin
      $display("FAIL tie_zero: got %0d required 0", dn.class_idx); n_fail++;
    end
    n_checks++;
    @(negedge clk);
    exp_frames++;
    if (dn.frame_cnt !== 8'(exp_frames)) begin
      $display("FAIL tie_frame_cnt: got %0d required %0d", dn.frame_cnt, exp_frames); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_backpressure();
    int hs0;
    dn.m_ready = 1'b0;
    send_frame(16'sd1, 16'sd2, 16'sd3, 16'sd40, 1'b0);
    hs0 = hs_count;
    up.s_valid = 1'b1;
    up.data_in = 16'sd99;
    for (int i = 0; i < 5; i++) begin
      if (dn.m_valid !== 1'b1 || dn.class_idx !== 3'd3 || up.s_ready !== 1'b0) begin
        $display("FAIL bp_hold[%0d]: m_valid=%b class_idx=%0d s_ready=%b required 1/3/0",
                 i, dn.m_valid, dn.class_idx, up.s_ready);
        n_fail++;
      end
      n_checks++;
      @(negedge clk);
    end
    up.s_valid = 1'b0;
    dn.m_ready = 1'b1;
    @(negedge clk);
    exp_frames++;
    if (dn.m_valid !== 1'b0 || up.s_ready !== 1'b1) begin
      $display("FAIL bp_release: m_valid=%b s_ready=%b required 0/1", dn.m_valid, up.s_ready);
      n_fail++;
    end
    n_checks++;
    if (hs_count - hs0 !== 1) begin
      $display("FAIL bp_handshakes: got %0d required 1", hs_count - hs0); n_fail++;
    end
    n_checks++;
    if (dn.frame_cnt !== 8'(exp_frames)) begin
      $display("FAIL bp_frame_cnt: got %0d required %0d", dn.frame_cnt, exp_frames); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_signed_gappy();
    send_frame(-16'sd3, -16'sd1, -16'sd8, -16'sd2, 1'b1);
    if (dn.m_valid !== 1'b1 || dn.class_idx !== 3'd1) begin
      $display("FAIL signed_idx: m_valid=%b class_idx=%0d required 1/1", dn.m_valid, dn.class_idx);
      n_fail++;
    end
    n_checks++;
`ifdef ARGMAX_VALUE_OUT_EN
    if (dn.max_val !== -16'sd1) begin
      $display("FAIL signed_max_val: got %0d required -1", dn.max_val); n_fail++;
    end
    n_checks++;
`endif
    @(negedge clk);
    exp_frames++;
  endtask

  task automatic test_reset_mid_frame();
    send_elem(16'sd10);
    send_elem(16'sd20);
    up.s_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    if (dn.m_valid !== 1'b0 || dn.frame_cnt !== 8'd0 || up.s_ready !== 1'b0) begin
      $display("FAIL midreset_async: m_valid=%b frame_cnt=%0d s_ready=%b required 0/0/0",
               dn.m_valid, dn.frame_cnt, up.s_ready);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    reset = 1'b1;
    exp_frames = 0;
    send_frame(16'sd1, 16'sd1, 16'sd50, 16'sd1, 1'b0);
    if (dn.class_idx !== 3'd2) begin
      $display("FAIL midreset_idx: got %0d required 2", dn.class_idx); n_fail++;
    end
    n_checks++;
    @(negedge clk);
    if (dn.frame_cnt !== 8'd1) begin
      $display("FAIL midreset_frame_cnt: got %0d required 1", dn.frame_cnt); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_wrap();
    int                  hs0;
    int                  idx;
    logic signed [T-1:0] v[4];
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    hs0 = hs_count;
    for (int k = 0; k < 257; k++) begin
      idx = k % 4;
      for (int j = 0; j < 4; j++) v[j] = (j == idx) ? 16'sd100 : 16'(j);
      send_frame(v[0], v[1], v[2], v[3], 1'b0);
      if (dn.class_idx !== 3'(idx)) begin
        $display("FAIL wrap_idx[%0d]: got %0d required %0d", k, dn.class_idx, idx); n_fail++;
      end
      n_checks++;
    end
    @(negedge clk);
    if (dn.frame_cnt !== 8'd1) begin
      $display("FAIL wrap_frame_cnt: got %0d required 1", dn.frame_cnt); n_fail++;
    end
    n_checks++;
    if (hs_count - hs0 !== 257) begin
      $display("FAIL wrap_handshakes: got %0d required 257", hs_count - hs0); n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    exp_frames = 0;
    reset      = 1'b0;
    up.s_valid = 1'b0;
    up.data_in = '0;
    dn.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_tie();
    test_backpressure();
    test_signed_gappy();
    test_reset_mid_frame();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
